// File: rtl/axi_llc_pkg.sv
// Shared LLC configuration, cache-unit identifiers and default channel types
// used by the eviction W-channel master.
package axi_llc_pkg;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned TagLength;
    int unsigned IndexLength;
    int unsigned BlockOffsetLength;
    int unsigned ByteOffsetLength;
  } llc_cfg_t;

  typedef struct packed {
    int unsigned IdWidthFull;
    int unsigned AddrWidthFull;
    int unsigned DataWidthFull;
  } llc_axi_cfg_t;

  typedef enum logic [1:0] {
    EvictUnit = 2'd0,
    RefilUnit = 2'd1,
    WChanUnit = 2'd2,
    RChanUnit = 2'd3
  } cache_unit_e;

  localparam int unsigned DefTagLength         = 19;
  localparam int unsigned DefIndexLength       = 8;
  localparam int unsigned DefBlockOffsetLength = 2;
  localparam int unsigned DefByteOffsetLength  = 3;
  localparam int unsigned DefWayIndWidth       = 4;
  localparam int unsigned DefDataWidth         = 64;

  localparam llc_cfg_t DefaultCfg = '{
    SetAssociativity:  16,
    NumLines:          256,
    NumBlocks:         4,
    TagLength:         DefTagLength,
    IndexLength:       DefIndexLength,
    BlockOffsetLength: DefBlockOffsetLength,
    ByteOffsetLength:  DefByteOffsetLength
  };

  localparam llc_axi_cfg_t DefaultAxiCfg = '{
    IdWidthFull:   4,
    AddrWidthFull: 32,
    DataWidthFull: DefDataWidth
  };

  typedef struct packed {
    logic                          evict;
    logic [DefWayIndWidth-1:0]     way_ind;
    logic [DefTagLength-1:0]       evict_tag;
    logic [31:0]                   a_x_addr;
  } llc_desc_t;

  typedef struct packed {
    cache_unit_e                   cache_unit;
    logic [DefWayIndWidth-1:0]     way_ind;
    logic [DefIndexLength-1:0]     line_addr;
    logic [DefBlockOffsetLength-1:0] blk_offset;
    logic                          we;
    logic [DefDataWidth-1:0]       data;
    logic [DefDataWidth/8-1:0]     strb;
  } llc_way_inp_t;

  typedef struct packed {
    cache_unit_e                   cache_unit;
    logic [DefDataWidth-1:0]       data;
  } llc_way_oup_t;

  typedef struct packed {
    logic [DefDataWidth-1:0]       data;
    logic [DefDataWidth/8-1:0]     strb;
    logic                          last;
    logic                          user;
  } llc_w_chan_t;

  function automatic int unsigned num_blocks(input llc_cfg_t cfg);
    return 32'd1 << cfg.BlockOffsetLength;
  endfunction

endpackage

// File: rtl/axi_llc_evict_w_master.sv
// Eviction write-data path: reads a victim line block by block from the data
// ways and streams it as one W burst, then forwards the descriptor.
module axi_llc_evict_w_master
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t     Cfg            = DefaultCfg,
  parameter llc_axi_cfg_t AxiCfg         = DefaultAxiCfg,
  parameter type          desc_t         = llc_desc_t,
  parameter type          way_inp_t      = llc_way_inp_t,
  parameter type          way_oup_t      = llc_way_oup_t,
  parameter type          w_chan_t       = llc_w_chan_t,
  parameter int unsigned  MaxOutstanding = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  desc_t    desc_i,
  input  logic     desc_valid_i,
  output logic     desc_ready_o,
  output desc_t    desc_o,
  output logic     desc_valid_o,
  input  logic     desc_ready_i,
  output way_inp_t way_inp_o,
  output logic     way_inp_valid_o,
  input  logic     way_inp_ready_i,
  input  way_oup_t way_out_i,
  input  logic     way_out_valid_i,
  output logic     way_out_ready_o,
  output w_chan_t  w_chan_mst_o,
  output logic     w_chan_valid_o,
  input  logic     w_chan_ready_i
);

  localparam int unsigned NumBlocks = num_blocks(Cfg);
  localparam int unsigned LineLsb   = Cfg.ByteOffsetLength + Cfg.BlockOffsetLength;

  typedef logic [Cfg.BlockOffsetLength-1:0]   offset_t;
  typedef logic [Cfg.BlockOffsetLength:0]     cnt_t;
  typedef logic [$clog2(MaxOutstanding+1)-1:0] outst_t;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Evict = 2'd1,
    Send  = 2'd2
  } state_e;

  state_e state_q;
  desc_t  desc_q;
  cnt_t   req_cnt_q, beat_cnt_q;
  outst_t outst_q;

  logic in_evict, req_hs, w_hs, last_beat, last_hs, desc_acc;

  always_comb begin
    in_evict        = (state_q == Evict);
    last_beat       = (beat_cnt_q == cnt_t'(NumBlocks - 1));
    way_inp_valid_o = in_evict && (req_cnt_q < cnt_t'(NumBlocks))
                      && (outst_q < outst_t'(MaxOutstanding));
    // W is a pure pass-through of the way response; no skid storage here.
    w_chan_valid_o  = in_evict && way_out_valid_i;
    way_out_ready_o = in_evict && w_chan_ready_i;
    req_hs          = way_inp_valid_o && way_inp_ready_i;
    w_hs            = w_chan_valid_o && w_chan_ready_i;
    last_hs         = w_hs && last_beat;
    desc_valid_o    = (state_q == Send) || last_hs;
    desc_ready_o    = (state_q == Idle) || (desc_valid_o && desc_ready_i);
    desc_acc        = desc_valid_i && desc_ready_o;
  end

  always_comb begin
    way_inp_o            = '0;
    way_inp_o.cache_unit = EvictUnit;
    way_inp_o.way_ind    = desc_q.way_ind;
    way_inp_o.line_addr  = desc_q.a_x_addr[LineLsb +: Cfg.IndexLength];
    way_inp_o.blk_offset = offset_t'(req_cnt_q[Cfg.BlockOffsetLength-1:0]);
    way_inp_o.we         = 1'b0;
  end

  always_comb begin
    w_chan_mst_o      = '0;
    w_chan_mst_o.data = way_out_i.data;
    w_chan_mst_o.strb = '1;
    w_chan_mst_o.last = last_beat;
    w_chan_mst_o.user = '0;
  end

  assign desc_o = desc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= Idle;
      desc_q     <= '0;
      req_cnt_q  <= '0;
      beat_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      if (req_hs) req_cnt_q  <= req_cnt_q + cnt_t'(1);
      if (w_hs)   beat_cnt_q <= beat_cnt_q + cnt_t'(1);
      case ({req_hs, w_hs})
        2'b10:   outst_q <= outst_q + outst_t'(1);
        2'b01:   outst_q <= outst_q - outst_t'(1);
        default: outst_q <= outst_q;
      endcase

      case (state_q)
        Idle:    state_q <= Idle;
        Evict:   if (last_hs) state_q <= desc_ready_i ? Idle : Send;
        Send:    if (desc_ready_i) state_q <= Idle;
        default: state_q <= Idle;
      endcase

      // A descriptor accepted on the retiring cycle overrides the Idle move.
      if (desc_acc) begin
        desc_q     <= desc_i;
        state_q    <= desc_i.evict ? Evict : Send;
        req_cnt_q  <= '0;
        beat_cnt_q <= '0;
        outst_q    <= '0;
      end
    end
  end

  logic unused_way_out;
  assign unused_way_out = ^way_out_i;

  a_outst_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    outst_q <= outst_t'(MaxOutstanding));
  a_w_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_chan_valid_o && !w_chan_ready_i) |=> (w_chan_valid_o && $stable(w_chan_mst_o)));
  a_way_resp_in_evict: assert property (@(posedge clk_i) disable iff (rst_i)
    way_out_valid_i |-> in_evict);
  a_beat_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    w_hs |-> (beat_cnt_q < cnt_t'(NumBlocks)));
  a_full_burst: assert property (@(posedge clk_i) disable iff (rst_i)
    last_hs |-> (req_cnt_q == cnt_t'(NumBlocks) && outst_q == outst_t'(1)));
  a_data_width: assert property (@(posedge clk_i)
    $bits(w_chan_mst_o.data) == AxiCfg.DataWidthFull);

endmodule

// File: tb/tb_axi_llc_evict_w_master.sv
// Directed and randomised bench for the eviction W master with a small
// in-order data-way model and a descriptor/beat scoreboard.
module tb_axi_llc_evict_w_master;
  import axi_llc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  llc_desc_t    desc_i, desc_o;
  logic         desc_valid_i, desc_ready_o, desc_valid_o, desc_ready_i;
  llc_way_inp_t way_inp_o;
  logic         way_inp_valid_o, way_inp_ready_i;
  llc_way_oup_t way_out_i;
  logic         way_out_valid_i, way_out_ready_o;
  llc_w_chan_t  w_chan_mst_o;
  logic         w_chan_valid_o, w_chan_ready_i;

  axi_llc_evict_w_master #(
    .Cfg(DefaultCfg), .AxiCfg(DefaultAxiCfg),
    .desc_t(llc_desc_t), .way_inp_t(llc_way_inp_t),
    .way_oup_t(llc_way_oup_t), .w_chan_t(llc_w_chan_t),
    .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .desc_i(desc_i), .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_o(desc_o), .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
    .way_inp_o(way_inp_o), .way_inp_valid_o(way_inp_valid_o), .way_inp_ready_i(way_inp_ready_i),
    .way_out_i(way_out_i), .way_out_valid_i(way_out_valid_i), .way_out_ready_o(way_out_ready_o),
    .w_chan_mst_o(w_chan_mst_o), .w_chan_valid_o(w_chan_valid_o), .w_chan_ready_i(w_chan_ready_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] way_data(input logic [3:0] w, input logic [7:0] l,
                                           input logic [1:0] o);
    return {8'hA5, 4'h0, w, l, 6'h0, o, 32'h0F0F_1234};
  endfunction

  // environment knobs
  bit w_rdy_rand = 0, w_rdy_val = 1;
  bit way_rdy_rand = 0, way_v_rand = 0;
  bit drdy_rand = 0, drdy_val = 1;

  // monitor / scoreboard state
  int cyc = 0;
  int acc_total = 0, out_total = 0, w_total = 0, req_total = 0;
  int acc_cyc = 0, out_cyc = 0, last_beat_cyc = 0;
  int tb_outst = 0, max_outst = 0, sb_beat = 0;
  logic [1:0]  req_off_q[$];
  int          req_cyc_q[$];
  logic        last_q[$];
  int          w_cyc_q[$];
  llc_desc_t   exp_q[$];
  logic [63:0] resp_pending[$];
  llc_way_inp_t last_req;
  bit          pop_pend = 0, flush_way = 0, out_v = 0;
  logic [63:0] out_d = '0;
  bit          prev_wv_nr = 0;
  llc_w_chan_t prev_w;

  task automatic clear_logs();
    req_off_q.delete(); req_cyc_q.delete(); last_q.delete(); w_cyc_q.delete();
    max_outst = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete(); resp_pending.delete();
      sb_beat = 0; tb_outst = 0; flush_way = 1; prev_wv_nr = 0;
    end else begin
      if (tb_outst == 2) chk("throttle", way_inp_valid_o, 1'b0);
      if (prev_wv_nr) begin
        chk("w_hold_valid", w_chan_valid_o, 1'b1);
        chk("w_hold_payload", w_chan_mst_o, prev_w);
      end
      prev_wv_nr = w_chan_valid_o && !w_chan_ready_i;
      prev_w     = w_chan_mst_o;

      if (way_inp_valid_o && way_inp_ready_i) begin
        req_off_q.push_back(way_inp_o.blk_offset);
        req_cyc_q.push_back(cyc);
        last_req = way_inp_o;
        resp_pending.push_back(way_data(way_inp_o.way_ind, way_inp_o.line_addr,
                                        way_inp_o.blk_offset));
        req_total++;
        tb_outst++;
      end
      if (way_out_valid_i && way_out_ready_o) pop_pend = 1;
      if (w_chan_valid_o && w_chan_ready_i) begin
        if (exp_q.size() == 0 || !exp_q[0].evict) begin
          chk("w_unexpected", 1'b1, 1'b0);
        end else begin
          chk("w_data", w_chan_mst_o.data,
              way_data(exp_q[0].way_ind, exp_q[0].a_x_addr[12:5], 2'(sb_beat)));
          chk("w_last", w_chan_mst_o.last, sb_beat == 3);
          chk("w_strb", w_chan_mst_o.strb, 8'hFF);
        end
        sb_beat++;
        last_q.push_back(w_chan_mst_o.last);
        w_cyc_q.push_back(cyc);
        if (w_chan_mst_o.last) last_beat_cyc = cyc;
        w_total++;
        tb_outst--;
      end
      if (tb_outst > max_outst) max_outst = tb_outst;

      if (desc_valid_o && desc_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("desc_unexpected", 1'b1, 1'b0);
        end else begin
          chk("desc_out", desc_o, exp_q[0]);
          if (exp_q[0].evict) chk("beats_per_desc", sb_beat, 4);
          void'(exp_q.pop_front());
        end
        sb_beat = 0;
        out_total++;
        out_cyc = cyc;
      end
      if (desc_valid_i && desc_ready_o) begin
        exp_q.push_back(desc_i);
        acc_total++;
        acc_cyc = cyc;
      end
    end
  end

  // input drivers settle a little after the falling edge
  always @(negedge clk) begin
    #2;
    if (flush_way) begin out_v = 0; pop_pend = 0; flush_way = 0; end
    if (pop_pend) begin out_v = 0; pop_pend = 0; end
    if (!out_v && resp_pending.size() > 0 && (!way_v_rand || $urandom_range(0, 2) != 0)) begin
      out_v = 1;
      out_d = resp_pending.pop_front();
    end
    way_out_valid_i      = out_v;
    way_out_i            = '0;
    way_out_i.cache_unit = EvictUnit;
    way_out_i.data       = out_d;
    way_inp_ready_i      = way_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    w_chan_ready_i       = w_rdy_rand ? ($urandom_range(0, 2) != 0) : w_rdy_val;
    desc_ready_i         = drdy_rand ? ($urandom_range(0, 1) != 0) : drdy_val;
  end

  task automatic send_desc(input llc_desc_t d);
    int n;
    n = acc_total;
    desc_i       = d;
    desc_valid_i = 1'b1;
    for (int t = 0; t < 300 && acc_total == n; t++) @(negedge clk);
    chk("desc_accept", acc_total != n, 1'b1);
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int t = 0; t < 3000 && out_total < target; t++) @(negedge clk);
    chk("desc_out_reached", out_total >= target, 1'b1);
  endtask

  function automatic llc_desc_t mk(input bit ev, input logic [3:0] w, input logic [31:0] a);
    llc_desc_t d;
    d = '0;
    d.evict = ev; d.way_ind = w; d.evict_tag = a[31:13]; d.a_x_addr = a;
    return d;
  endfunction

  initial begin
    llc_desc_t d;
    int base_w, base_r, base_o, acc_b, nev;
    rst = 1'b1; desc_valid_i = 1'b0; desc_i = '0;
    way_inp_ready_i = 1'b1; way_out_valid_i = 1'b0; way_out_i = '0;
    w_chan_ready_i = 1'b1; desc_ready_i = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_desc_ready", desc_ready_o, 1'b1);
    chk("rst_desc_valid", desc_valid_o, 1'b0);
    chk("rst_way_valid", way_inp_valid_o, 1'b0);
    chk("rst_w_valid", w_chan_valid_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single evict, 1-cycle ways, W always ready
    clear_logs();
    d = mk(1'b1, 4'h5, 32'h0000_1234);
    send_desc(d);
    wait_out(1);
    chk("t1_req_cnt", req_off_q.size(), 4);
    chk("t1_offsets", {req_off_q[0], req_off_q[1], req_off_q[2], req_off_q[3]}, 8'h1B);
    chk("t1_last", {last_q[0], last_q[1], last_q[2], last_q[3]}, 4'b0001);
    chk("t1_first_req_lat", req_cyc_q[0] - acc_cyc, 1);
    chk("t1_desc_with_last", out_cyc, last_beat_cyc);
    chk("t1_line_addr", last_req.line_addr, 8'h91);
    chk("t1_way_ind", last_req.way_ind, 4'h5);
    chk("t1_unit", last_req.cache_unit, EvictUnit);
    chk("t1_we", last_req.we, 1'b0);
    @(negedge clk);
    chk("t1_idle_ready", desc_ready_o, 1'b1);
    chk("t1_idle_valid", desc_valid_o, 1'b0);

    // 2: pass-through descriptor held under backpressure
    base_w = w_total; base_r = req_total;
    drdy_val = 1'b0;
    @(negedge clk);
    d = mk(1'b0, 4'h3, 32'hABCD_0040);
    send_desc(d);
    repeat (3) begin
      chk("t2_valid", desc_valid_o, 1'b1);
      chk("t2_desc_hold", desc_o, d);
      chk("t2_not_ready", desc_ready_o, 1'b0);
      @(negedge clk);
    end
    drdy_val = 1'b1;
    wait_out(2);
    chk("t2_out_lat", out_cyc - acc_cyc, 4);
    chk("t2_no_req", req_total - base_r, 0);
    chk("t2_no_w", w_total - base_w, 0);

    // 3: W stalled for 5 cycles after beat 1
    clear_logs();
    base_w = w_total;
    d = mk(1'b1, 4'hC, 32'h0001_F8A0);
    send_desc(d);
    for (int t = 0; t < 50 && w_total < base_w + 2; t++) @(negedge clk);
    w_rdy_val = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_w_valid_held", w_chan_valid_o, 1'b1);
      chk("t3_no_req", way_inp_valid_o, 1'b0);
    end
    chk("t3_stalled_beats", w_total - base_w, 2);
    w_rdy_val = 1'b1;
    wait_out(3);
    chk("t3_max_outst", max_outst, 2);
    chk("t3_beats", w_total - base_w, 4);

    // 4: back-to-back evicts
    clear_logs();
    send_desc(mk(1'b1, 4'h1, 32'h0000_0100));
    send_desc(mk(1'b1, 4'h2, 32'h0000_0200));
    acc_b = acc_cyc;
    wait_out(5);
    chk("t4_last", {last_q[0], last_q[1], last_q[2], last_q[3],
                    last_q[4], last_q[5], last_q[6], last_q[7]}, 8'b0001_0001);
    chk("t4_accept_in_last", acc_b, w_cyc_q[3]);
    chk("t4_gap", w_cyc_q[4] - w_cyc_q[3], 2);

    // 5: reset mid-burst
    base_w = w_total;
    send_desc(mk(1'b1, 4'h7, 32'h0000_3FE0));
    for (int t = 0; t < 50 && w_total < base_w + 3; t++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_desc_valid", desc_valid_o, 1'b0);
    chk("t5_way_valid", way_inp_valid_o, 1'b0);
    chk("t5_w_valid", w_chan_valid_o, 1'b0);
    chk("t5_desc_ready", desc_ready_o, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    base_o = out_total;
    send_desc(mk(1'b1, 4'h9, 32'h0000_0AC0));
    wait_out(base_o + 1);
    chk("t5_first_off", req_off_q[0], 2'd0);
    chk("t5_req_cnt", req_off_q.size(), 4);
    chk("t5_last", {last_q[0], last_q[1], last_q[2], last_q[3]}, 4'b0001);

    // 6: random traffic
    w_rdy_rand = 1; way_rdy_rand = 1; way_v_rand = 1; drdy_rand = 1;
    base_o = out_total; base_w = w_total; nev = 0;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = mk($urandom_range(0, 2) != 0, 4'($urandom), $urandom);
      if (d.evict) nev++;
      send_desc(d);
    end
    wait_out(base_o + 200);
    chk("t6_descs", out_total - base_o, 200);
    chk("t6_beats", w_total - base_w, 4 * nev);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
